// File: rtl/stream_fifo.sv
// Synchronous valid/ready stream FIFO with preload, occupancy flags, flush and eot-flush.
// Define STREAM_FIFO_OUTREG_EN to add a registered output stage (capacity DEPTH+1).
module stream_fifo #(
  parameter int W_DATA       = 8,
  parameter int DEPTH        = 32,
  parameter int PRELOAD      = 4,
  parameter int AFULL_TH     = DEPTH - 2,
  parameter int AEMPTY_TH    = 2,
  parameter int FLUSH_ON_EOT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic [W_DATA-1:0]        din_data,
  input  logic [1:0]               din_eot,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [W_DATA-1:0]        dout_data,
  output logic [1:0]               dout_eot,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = W_DATA + 2;
  localparam logic [PW-1:0] PRELOAD_PTR = PW'(PRELOAD);
  localparam logic [PW-1:0] AFULL_LV    = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_LV   = PW'(AEMPTY_TH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 4");
  end
  if (PRELOAD < 0 || PRELOAD > DEPTH) begin : g_bad_preload
    $error("stream_fifo: PRELOAD must lie in 0..DEPTH");
  end
  if (AFULL_TH > DEPTH) begin : g_bad_afull
    $error("stream_fifo: AFULL_TH must not exceed DEPTH");
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          mem_empty, mem_full;
  logic [PW-1:0] mem_level;
  logic          wr_en, mem_rd, eot_flush, clear;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign mem_level = wr_ptr_q - rd_ptr_q;

  assign din_ready = ~mem_full;
  assign wr_en     = din_valid & din_ready;
  // Only an accepted end-of-frame word triggers the flush; a bare eot[1] is ignored.
  assign eot_flush = (FLUSH_ON_EOT != 0) && wr_en && din_eot[1];
  assign clear     = flush | eot_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = PRELOAD_PTR;
      rd_ptr_d = '0;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q[AW-1:0]] = {din_eot, din_data};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (mem_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PRELOAD_PTR;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef STREAM_FIFO_OUTREG_EN
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_entry_q, out_entry_d;

  // The output register refills from the memory head whenever it is empty or being consumed.
  assign mem_rd = ~mem_empty & (~out_valid_q | dout_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_entry_d = '0;
    end else if (mem_rd) begin
      out_valid_d = 1'b1;
      out_entry_d = mem_q[rd_ptr_q[AW-1:0]];
    end else if (dout_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
    end
  end

  assign dout_valid = out_valid_q;
  assign dout_data  = out_entry_q[W_DATA-1:0];
  assign dout_eot   = out_entry_q[EW-1:W_DATA];
  assign level      = mem_level + {{AW{1'b0}}, out_valid_q};
`else
  logic [EW-1:0] head;

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign dout_valid = ~mem_empty;
  assign mem_rd     = dout_valid & dout_ready;
  assign dout_data  = head[W_DATA-1:0];
  assign dout_eot   = head[EW-1:W_DATA];
  assign level      = mem_level;
`endif

  assign almost_full  = (level >= AFULL_LV);
  assign almost_empty = (level <= AEMPTY_LV);

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: queue-based reference model plus directed literal checks.
// Instance B differs only by FLUSH_ON_EOT=0 and shares all inputs with instance A.
module tb_stream_fifo;

  localparam int DEPTH   = 8;
  localparam int PRELOAD = 4;

  logic       clk = 1'b0;
  logic       rst, flush, din_valid, dout_ready;
  logic [7:0] din_data;
  logic [1:0] din_eot;

  logic       din_ready, dout_valid, almost_full, almost_empty;
  logic [7:0] dout_data;
  logic [1:0] dout_eot;
  logic [3:0] level;

  logic       b_din_ready, b_dout_valid, b_almost_full, b_almost_empty;
  logic [7:0] b_dout_data;
  logic [1:0] b_dout_eot;
  logic [3:0] b_level;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;
  bit stream_en = 0;
  logic [7:0] exp_rx = 8'd1;
  int rx_cnt = 0;

  logic [9:0] mq [$];
  bit         sv;
  logic [9:0] sd;

  always #5 clk = ~clk;

  stream_fifo #(.W_DATA(8), .DEPTH(DEPTH), .PRELOAD(PRELOAD), .AFULL_TH(DEPTH-2),
                .AEMPTY_TH(2), .FLUSH_ON_EOT(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_eot(din_eot),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_eot(dout_eot),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  stream_fifo #(.W_DATA(8), .DEPTH(DEPTH), .PRELOAD(PRELOAD), .AFULL_TH(DEPTH-2),
                .AEMPTY_TH(2), .FLUSH_ON_EOT(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .din_valid(din_valid), .din_ready(b_din_ready), .din_data(din_data), .din_eot(din_eot),
    .dout_valid(b_dout_valid), .dout_ready(dout_ready), .dout_data(b_dout_data), .dout_eot(b_dout_eot),
    .level(b_level), .almost_full(b_almost_full), .almost_empty(b_almost_empty)
  );

  // Reference model: a queue of stored words plus an optional output slot.
  function automatic bit m_valid();
`ifdef STREAM_FIFO_OUTREG_EN
    return sv;
`else
    return mq.size() > 0;
`endif
  endfunction

  function automatic logic [9:0] m_head();
`ifdef STREAM_FIFO_OUTREG_EN
    return sd;
`else
    return (mq.size() > 0) ? mq[0] : 10'd0;
`endif
  endfunction

  function automatic int m_level();
    return mq.size() + int'(sv);
  endfunction

  function automatic bit m_din_ready();
    return mq.size() < DEPTH;
  endfunction

  task automatic modelPreload();
    mq.delete();
    for (int i = 0; i < PRELOAD; i++) mq.push_back(10'd0);
    sv = 1'b0;
    sd = 10'd0;
  endtask

  always @(posedge clk) begin
    automatic bit w = din_valid && m_din_ready();
    automatic bit r = m_valid() && dout_ready;
    if (rst || flush || (w && din_eot[1])) begin
      modelPreload();
    end else begin
`ifdef STREAM_FIFO_OUTREG_EN
      if (mq.size() > 0 && (!sv || dout_ready)) begin
        sd = mq.pop_front();
        sv = 1'b1;
      end else if (r) begin
        sv = 1'b0;
      end
`else
      if (r) void'(mq.pop_front());
`endif
      if (w) mq.push_back({din_eot, din_data});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; returns shortly after the edge that consumed them.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] e,
                               input logic rdy, input logic fl);
    din_valid  = v;
    din_data   = d;
    din_eot    = e;
    dout_ready = rdy;
    flush      = fl;
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_din_ready", {31'd0, din_ready}, {31'd0, m_din_ready()});
      checkOutput("cyc_level", {28'd0, level}, m_level());
      checkOutput("cyc_almost_full", {31'd0, almost_full}, {31'd0, m_level() >= DEPTH - 2});
      checkOutput("cyc_almost_empty", {31'd0, almost_empty}, {31'd0, m_level() <= 2});
      checkOutput("cyc_dout_valid", {31'd0, dout_valid}, {31'd0, m_valid()});
      if (m_valid()) checkOutput("cyc_dout_word", {22'd0, dout_eot, dout_data}, {22'd0, m_head()});
      if (stream_en && dout_valid && dout_ready) begin
        checkOutput("stream_order", {24'd0, dout_data}, {24'd0, exp_rx});
        exp_rx++;
        rx_cnt++;
      end
    end
  end

  initial begin
    int sent, cyc;
    bit v, rdy, acc;
    logic [7:0] exp3 [3];
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;

    rst = 1'b1; flush = 1'b0; din_valid = 1'b0; din_data = '0; din_eot = '0; dout_ready = 1'b0;
    modelPreload();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

`ifndef STREAM_FIFO_OUTREG_EN
    checkOutput("rst_level", {28'd0, level}, 32'd4);
    checkOutput("rst_dout_valid", {31'd0, dout_valid}, 32'd1);
    checkOutput("rst_dout_data", {24'd0, dout_data}, 32'd0);
    checkOutput("rst_din_ready", {31'd0, din_ready}, 32'd1);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA1 + 8'(i), 2'b00, 1'b0, 1'b0);
    checkOutput("fill_level", {28'd0, level}, 32'd8);
    checkOutput("fill_din_ready", {31'd0, din_ready}, 32'd0);
    checkOutput("fill_almost_full", {31'd0, almost_full}, 32'd1);

    applyStimulus(1'b1, 8'hB1, 2'b00, 1'b1, 1'b0);
    checkOutput("full_rw_level", {28'd0, level}, 32'd7);
    applyStimulus(1'b1, 8'hB1, 2'b00, 1'b0, 1'b0);
    checkOutput("full_rw_refill", {28'd0, level}, 32'd8);
`endif

    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    checkOutput("drain_empty", {31'd0, dout_valid}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, exp3[i], 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("order_head", {24'd0, dout_data}, {24'd0, exp3[i]});
      applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    end
    checkOutput("order_level", {28'd0, level}, 32'd0);
    checkOutput("order_dout_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("order_almost_empty", {31'd0, almost_empty}, 32'd1);

    applyStimulus(1'b1, 8'h77, 2'b00, 1'b0, 1'b0);
`ifdef STREAM_FIFO_OUTREG_EN
    checkOutput("lat_cycle1_valid", {31'd0, dout_valid}, 32'd0);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
`endif
    checkOutput("lat_valid", {31'd0, dout_valid}, 32'd1);
    checkOutput("lat_data", {24'd0, dout_data}, 32'h77);
    applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    checkOutput("lat_drained", {28'd0, level}, 32'd0);

    stream_en = 1'b1;
    sent = 0;
    cyc = 0;
    while ((sent < 40 || m_level() > 0) && cyc < 400) begin
      v   = (sent < 40);
      rdy = (cyc % 3 != 1);
      acc = v && m_din_ready();
      applyStimulus(v, 8'(sent + 1), 2'b00, rdy, 1'b0);
      if (acc) sent++;
      cyc++;
    end
    stream_en = 1'b0;
    checkOutput("stream_count", rx_cnt, 32'd40);
    checkOutput("stream_timeout", {31'd0, cyc >= 400}, 32'd0);

    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h99, 2'b10, 1'b0, 1'b0);
    checkOutput("bare_eot_level", {28'd0, level}, 32'd4);
    applyStimulus(1'b1, 8'hAA, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCC, 2'b10, 1'b0, 1'b0);
    checkOutput("eotflush_level", {28'd0, level}, 32'd4);
`ifndef STREAM_FIFO_OUTREG_EN
    checkOutput("eotflush_data", {24'd0, dout_data}, 32'd0);
    checkOutput("eotkeep_level", {28'd0, b_level}, 32'd7);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    checkOutput("eotkeep_data", {24'd0, b_dout_data}, 32'hCC);
    checkOutput("eotkeep_eot", {30'd0, b_dout_eot}, 32'd2);
`endif

    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h44, 2'b00, 1'b0, 1'b0);
    checkOutput("pre_flush_level", {28'd0, level}, 32'd5);
    applyStimulus(1'b1, 8'h55, 2'b00, 1'b0, 1'b1);
    checkOutput("flush_write_level", {28'd0, level}, 32'd4);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    checkOutput("flush_write_drained", {28'd0, level}, 32'd0);

    applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous stream FIFO for the classifier's pixel and feature pipelines. It is the successor to the basic preload FIFO and adds:
- occupancy reporting, almost-full and almost-empty flags;
- an explicit flush input, and end-of-frame flush that can be disabled by parameter;
- checked preload, and an optional registered output stage.

It sits between the image-window producers and the cascade stage consumers, using valid/ready handshakes with a 2-bit end-of-transfer (eot) sideband.

## Interface
- W_DATA, 8: payload width in bits.
- DEPTH, 32: storage entries; must be a power of two, ≥ 4.
- PRELOAD, 4: zero-valued entries present after reset/flush; 0 ≤ PRELOAD ≤ DEPTH.
- AFULL_TH, DEPTH-2: almost_full asserts when level ≥ AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when level ≤ AEMPTY_TH.
- FLUSH_ON_EOT, 1: 1 means an accepted word with din_eot[1]=1 flushes the FIFO.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear to the preload state; same effect as rst on FIFO state.
- din_valid  in  1  write request.
- din_ready  out  1  = ~full.
- din_data  in  W_DATA  write payload.
- din_eot  in  2  [0] end of row, [1] end of frame.
- dout_valid  out  1  = ~empty (output side).
- dout_ready  in  1  read acknowledge.
- dout_data  out  W_DATA  head payload.
- dout_eot  out  2  head eot.
- level  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- almost_full, almost_empty  out  1  threshold flags, combinational from level.

## Operation
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - empty: the pointers are fully equal.
  - full: the low bits are equal and the MSBs differ.
  - level = wr_ptr − rd_ptr, modulo 2·DEPTH.
- Write: din_valid & din_ready stores {din_eot, din_data} at wr_ptr and increments wr_ptr.
- Read: dout_valid & dout_ready increments rd_ptr.
- A write and a read in the same cycle are both performed and level is unchanged.
- When full, din_ready=0 even if dout_ready=1; there is no full-cycle pass-through.
- Reset or flush sets:
  - rd_ptr=0 and wr_ptr=PRELOAD;
  - all memory data and eot entries to 0;
  - level=PRELOAD.
  - Any handshake in that same cycle is discarded.
- End-of-frame flush (FLUSH_ON_EOT=1): a write accepted with din_eot[1]=1 is not stored; the next state is the preload state.
  - din_eot[1] without din_valid has no effect. This differs deliberately from the previous FIFO generation, which flushed on din_eot[1] regardless of din_valid.
- FLUSH_ON_EOT=0: the eot word is stored like any other word.
- Priority: rst > flush > eot-flush > normal write/read.
- Elaboration fails on a non-power-of-two DEPTH, PRELOAD > DEPTH, or AFULL_TH > DEPTH.

## Timing
Reset values:
- din_ready=1, or 0 if PRELOAD = DEPTH.
- dout_valid=1 if PRELOAD > 0; dout_data=0 and dout_eot=0.
- level=PRELOAD.
- Flags are computed from level.

Latency and flags:
- Write-to-dout_valid latency is 1 cycle from the accepting edge when empty.
- din_ready deasserts in the cycle after the write that fills the FIFO.
- Flags update in the same cycle as level; no extra register.
- Wrap-around: exercise a wr_ptr pass from 2·DEPTH−1 to 0 with no change in data order.

## Configuration
- STREAM_FIFO_OUTREG_EN defined:
  - dout_data, dout_eot and dout_valid are driven from a register stage fed from the memory head.
  - Write-to-dout_valid latency becomes 2 cycles.
  - level counts memory plus the output register, so capacity is DEPTH+1 and level is 0..DEPTH+1.
  - The register is cleared on rst/flush; preload entries are then presented after 1 cycle.
- Not defined: dout is a combinational read of mem[rd_ptr], the output stage is absent, and capacity is DEPTH.

## Test plan
- Reset, DEPTH=8, PRELOAD=4, dout_ready=0 → level=4, dout_valid=1, dout_data=0, din_ready=1; write 4 words → din_ready=0 on the next cycle, level=8, almost_full=1.
- Drain 4 zero preload entries, then write 0x11, 0x22, 0x33 → read back 0x11, 0x22, 0x33 in order; then empty, dout_valid=0, almost_empty=1.
- Full FIFO with din_valid=1 and dout_ready=1 for one cycle → only the read occurs; level goes from 8 to 7; the next cycle the write is accepted and level returns to 8.
- Stream 40 words with dout_ready toggling 1,0,1 (DEPTH=8) → all 40 words are received in order across multiple pointer wraps, with no drop and no duplicate.
- FLUSH_ON_EOT=1: write 0xAA, 0xBB, then 0xCC with din_eot=2'b10 → the next cycle has level=PRELOAD and dout_data=0; 0xAA, 0xBB and 0xCC are never output. Repeat with FLUSH_ON_EOT=0 → 0xCC is output with dout_eot=2'b10.
- flush asserted together with a write of 0x55 while level=5 → next cycle level=PRELOAD and 0x55 is absent; under STREAM_FIFO_OUTREG_EN, the first read of 0x77 written to an empty FIFO arrives 2 cycles after the write.
